// File: rtl/pc_redirect_unit.sv
// Fetch-stage program counter with branch, jump and jump-register redirects.
// Emits a registered redirect pulse used to flush IF/ID.
module pc_redirect_unit #(
    parameter int MSB = 32,
    parameter logic [MSB-1:0] RESET_PC = '0,
    parameter int PC_STEP = 4,
    parameter int OFFSET_SHIFT = 2,
    parameter int JIDX = 26
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_enable,
    input  logic            i_halt,
    input  logic            i_branch_taken,
    input  logic [MSB-1:0]  i_branch_base,
    input  logic [MSB-1:0]  i_branch_offset,
    input  logic            i_jump,
    input  logic [JIDX-1:0] i_jump_index,
    input  logic            i_jump_reg,
    input  logic [MSB-1:0]  i_jr_addr,
    output logic [MSB-1:0]  o_pc,
    output logic [MSB-1:0]  o_next_pc,
    output logic [MSB-1:0]  o_branch_addr,
    output logic            o_redirect,
    output logic            o_halted,
    output logic            o_addr_err
);

    localparam int TOP = JIDX + OFFSET_SHIFT;
    localparam logic [MSB-1:0] STEP = MSB'(PC_STEP);

    typedef enum logic {
        S_RUN,
        S_HALTED
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [MSB-1:0] r_pc;
    logic [MSB-1:0] w_pc_nxt;
    logic [MSB-1:0] w_jump_tgt;
    logic [MSB-1:0] w_jr_tgt;
    logic           r_redirect;
    logic           w_redirect_nxt;
    logic           r_addr_err;
    logic           w_addr_err_nxt;

    assign o_next_pc     = r_pc + STEP;
    assign o_branch_addr = i_branch_base + (i_branch_offset << OFFSET_SHIFT);
    assign w_jump_tgt    = {o_next_pc[MSB-1:TOP], i_jump_index,
                            {OFFSET_SHIFT{1'b0}}};
    assign w_jr_tgt      = {i_jr_addr[MSB-1:OFFSET_SHIFT],
                            {OFFSET_SHIFT{1'b0}}};

    assign o_pc       = r_pc;
    assign o_redirect = r_redirect;
    assign o_halted   = (r_state == S_HALTED);
    assign o_addr_err = r_addr_err;

    // Fixed priority: halt, branch, jump-register, jump, stall, sequential.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_redirect_nxt = 1'b0;
        w_addr_err_nxt = r_addr_err;
        if (r_state == S_RUN) begin
            if (i_halt) begin
                w_state_nxt = S_HALTED;
            end else if (i_branch_taken) begin
                w_pc_nxt       = o_branch_addr;
                w_redirect_nxt = 1'b1;
            end else if (i_jump_reg) begin
                w_pc_nxt       = w_jr_tgt;
                w_redirect_nxt = 1'b1;
                if (i_jr_addr[OFFSET_SHIFT-1:0] != '0) begin
                    w_addr_err_nxt = 1'b1;
                end
            end else if (i_jump) begin
                w_pc_nxt       = w_jump_tgt;
                w_redirect_nxt = 1'b1;
            end else if (i_enable) begin
                w_pc_nxt = o_next_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_redirect <= w_redirect_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: stimulus pushes expected state,
// a monitor pops and compares one entry after each rising edge.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_enable;
    logic        i_halt;
    logic        i_branch_taken;
    logic [31:0] i_branch_base;
    logic [31:0] i_branch_offset;
    logic        i_jump;
    logic [25:0] i_jump_index;
    logic        i_jump_reg;
    logic [31:0] i_jr_addr;
    logic [31:0] o_pc;
    logic [31:0] o_next_pc;
    logic [31:0] o_branch_addr;
    logic        o_redirect;
    logic        o_halted;
    logic        o_addr_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        redir;
        logic        halted;
        logic        err;
        logic        chk_ba;
        logic [31:0] ba;
    } exp_t;

    exp_t q[$];

    pc_redirect_unit dut (
        .clk            (clk),
        .reset          (reset),
        .i_enable       (i_enable),
        .i_halt         (i_halt),
        .i_branch_taken (i_branch_taken),
        .i_branch_base  (i_branch_base),
        .i_branch_offset(i_branch_offset),
        .i_jump         (i_jump),
        .i_jump_index   (i_jump_index),
        .i_jump_reg     (i_jump_reg),
        .i_jr_addr      (i_jr_addr),
        .o_pc           (o_pc),
        .o_next_pc      (o_next_pc),
        .o_branch_addr  (o_branch_addr),
        .o_redirect     (o_redirect),
        .o_halted       (o_halted),
        .o_addr_err     (o_addr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (o_pc !== e.pc || o_redirect !== e.redir ||
                o_halted !== e.halted || o_addr_err !== e.err ||
                o_next_pc !== e.pc + 32'd4 ||
                (e.chk_ba && o_branch_addr !== e.ba)) begin
                n_bad++;
                $display("FAIL %s: got pc=%h nxt=%h ba=%h r=%b h=%b e=%b exp pc=%h nxt=%h ba=%h r=%b h=%b e=%b",
                         e.name, o_pc, o_next_pc, o_branch_addr,
                         o_redirect, o_halted, o_addr_err,
                         e.pc, e.pc + 32'd4, e.ba, e.redir, e.halted, e.err);
            end
        end
    end

    task automatic idle();
        reset           = 1'b0;
        i_enable        = 1'b1;
        i_halt          = 1'b0;
        i_branch_taken  = 1'b0;
        i_branch_base   = '0;
        i_branch_offset = '0;
        i_jump          = 1'b0;
        i_jump_index    = '0;
        i_jump_reg      = 1'b0;
        i_jr_addr       = '0;
    endtask

    // Push the state expected after the coming edge, then move to the next
    // falling edge where the following inputs are driven.
    task automatic go(input string n, input logic [31:0] pc,
                      input logic r, input logic h, input logic e,
                      input logic cb, input logic [31:0] ba);
        exp_t x;
        x.name = n; x.pc = pc; x.redir = r; x.halted = h;
        x.err = e; x.chk_ba = cb; x.ba = ba;
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        go("reset0", 32'h0, 0, 0, 0, 0, 0);
        go("reset1", 32'h0, 0, 0, 0, 0, 0);
        idle();
        go("seq4", 32'h4, 0, 0, 0, 0, 0);
        go("seq8", 32'h8, 0, 0, 0, 0, 0);
        go("seq12", 32'hC, 0, 0, 0, 0, 0);

        i_enable = 0; i_branch_base = 32'h1; i_branch_offset = 32'h2;
        go("ba_comb", 32'hC, 0, 0, 0, 1, 32'h9);
        i_enable = 1; i_branch_taken = 1;
        i_branch_base = 32'h100; i_branch_offset = 32'hFFFF_FFFF;
        go("br_neg", 32'hFC, 1, 0, 0, 1, 32'hFC);
        idle();
        go("br_after", 32'h100, 0, 0, 0, 0, 0);

        i_branch_taken = 1; i_branch_base = 32'h40; i_branch_offset = 32'h1;
        i_jump = 1; i_jump_index = 26'h7; i_jump_reg = 1; i_jr_addr = 32'h83;
        go("prio_all", 32'h44, 1, 0, 0, 1, 32'h44);
        idle();
        go("prio_after", 32'h48, 0, 0, 0, 0, 0);

        i_branch_taken = 1; i_branch_base = 32'h20;
        go("to_20", 32'h20, 1, 0, 0, 0, 0);
        idle(); i_enable = 0;
        go("stall0", 32'h20, 0, 0, 0, 0, 0);
        go("stall1", 32'h20, 0, 0, 0, 0, 0);
        go("stall2", 32'h20, 0, 0, 0, 0, 0);

        idle(); i_jump_reg = 1; i_jr_addr = 32'h1000_0010;
        go("jr_align", 32'h1000_0010, 1, 0, 0, 0, 0);
        idle(); i_enable = 0; i_jump = 1; i_jump_index = 26'h5;
        go("jmp_stall", 32'h1000_0014, 1, 0, 0, 0, 0);
        idle();
        go("jmp_after", 32'h1000_0018, 0, 0, 0, 0, 0);

        i_jump_reg = 1; i_jr_addr = 32'h33;
        go("jr_misal", 32'h30, 1, 0, 1, 0, 0);
        idle();
        go("err_sticky", 32'h34, 0, 0, 1, 0, 0);
        i_jump_reg = 1; i_jr_addr = 32'hFFFF_FFFC;
        go("jr_top", 32'hFFFF_FFFC, 1, 0, 1, 0, 0);
        idle();
        go("wrap", 32'h0, 0, 0, 1, 0, 0);
        go("post_wrap", 32'h4, 0, 0, 1, 0, 0);

        i_halt = 1; i_branch_taken = 1;
        i_branch_base = 32'h40; i_branch_offset = 32'h1;
        go("halt_br", 32'h4, 0, 1, 1, 1, 32'h44);
        for (int k = 0; k < 5; k++) begin
            idle();
            i_branch_taken = k[0]; i_branch_base = 32'h200;
            i_jump = 1; i_jump_index = 26'h3F;
            i_jump_reg = ~k[0]; i_jr_addr = 32'h501;
            go("halt_hold", 32'h4, 0, 1, 1, 1, 32'h200);
        end

        reset = 1'b1; i_jump = 1;
        go("reset_halt", 32'h0, 0, 0, 0, 0, 0);
        idle();
        go("run_again", 32'h4, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
